// File: rtl/i2s_rx_deserializer_pkg.sv
// i2s_rx_deserializer_pkg
// Shared audio definitions for the I2S receive path:
//   rx_state_e        receiver framing state (WAIT_SYNC / LEFT / RIGHT)
//   I2S_SAMPLE_WIDTH  captured bits per channel
//   LR_LEFT           LRCLK level that marks the left slot
`timescale 1ns/1ps
package i2s_rx_deserializer_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } rx_state_e;

    localparam int   I2S_SAMPLE_WIDTH = 24;
    localparam logic LR_LEFT          = 1'b0;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// i2s_rx_deserializer_if
// Bundles the codec-side I2S inputs, the enable and the captured-sample outputs.
//   enable, i2s_bclk, i2s_lrclk, i2s_sdata   into the receiver
//   line_in_l, line_in_r                      last complete L/R samples
//   new_sample, short_word, synced            status strobes / level
// master: the side driving the serial link and consuming samples.
// slave : the receiver itself.
`timescale 1ns/1ps
interface i2s_rx_deserializer_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                    enable;
    logic                    i2s_bclk;
    logic                    i2s_lrclk;
    logic                    i2s_sdata;
    logic [SAMPLE_WIDTH-1:0] line_in_l;
    logic [SAMPLE_WIDTH-1:0] line_in_r;
    logic                    new_sample;
    logic                    short_word;
    logic                    synced;

    modport master (
        output enable, i2s_bclk, i2s_lrclk, i2s_sdata,
        input  line_in_l, line_in_r, new_sample, short_word, synced
    );

    modport slave (
        input  enable, i2s_bclk, i2s_lrclk, i2s_sdata,
        output line_in_l, line_in_r, new_sample, short_word, synced
    );
endinterface

// File: rtl/i2s_rx_deserializer_sync_edge_detect.sv
// sync_edge_detect
// Multi-stage synchronizer for a group of asynchronous inputs, all delayed by
// the same number of stages, plus a rise detector on bit 0.
//   clk, reset  system clock / async active-high reset
//   d           raw asynchronous inputs
//   q           synchronized inputs (SYNC_STAGES clk of delay)
//   rise        q[0] was 0 in the previous clk and is 1 now
`timescale 1ns/1ps
module sync_edge_detect #(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rise
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
    logic                              prev_q, prev_d;

    always_comb begin
        stage_d[0] = d;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
        prev_d = stage_q[SYNC_STAGES-1][0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
        end
    end

    assign q    = stage_q[SYNC_STAGES-1];
    assign rise = stage_q[SYNC_STAGES-1][0] & ~prev_q;
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer
// Receive half of the codec I2S link. Deserializes ADC serial data into
// SAMPLE_WIDTH-bit left/right samples on the system clock.
//   clk, reset      system clock / async active-high reset
//   bus (slave)     enable and I2S inputs in; line_in_l/r, new_sample,
//                   short_word, synced out
// Framing: LRCLK low = left, MSB one BCLK after the LRCLK edge, bits taken on
// BCLK rises. The bit taken at an LRCLK edge belongs to the closing slot.
`timescale 1ns/1ps
module i2s_rx_deserializer
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    i2s_rx_deserializer_if.slave  bus
);
    localparam int                CNT_W    = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);

    logic [2:0] sync_q;
    logic       bclk_rise;
    logic       lr, sd;

    sync_edge_detect #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({bus.i2s_sdata, bus.i2s_lrclk, bus.i2s_bclk}),
        .q     (sync_q),
        .rise  (bclk_rise)
    );

    assign lr = sync_q[1];
    assign sd = sync_q[2];

    rx_state_e                state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0]  shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0]  left_hold_q, left_hold_d;
    logic [SAMPLE_WIDTH-1:0]  line_l_q, line_l_d;
    logic [SAMPLE_WIDTH-1:0]  line_r_q, line_r_d;
    logic                     lr_prev_q, lr_prev_d;
    logic                     pub_q, pub_d;
    logic                     new_sample_q, new_sample_d;
    logic                     short_word_q, short_word_d;

    logic [CNT_W-1:0]         cnt_app;
    logic [SAMPLE_WIDTH-1:0]  shift_app;
    logic [SAMPLE_WIDTH-1:0]  closed_word;
    logic                     lr_edge;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        line_l_d     = line_l_q;
        line_r_d     = line_r_q;
        lr_prev_d    = lr_prev_q;
        pub_d        = 1'b0;
        short_word_d = 1'b0;
        // new_sample trails the line_in register update by one clk
        new_sample_d = pub_q;

        // Current bit appended under the saturating-count rule
        cnt_app   = bit_cnt_q;
        shift_app = shift_q;
        if (bit_cnt_q < FULL_CNT) begin
            shift_app = {shift_q[SAMPLE_WIDTH-2:0], sd};
            cnt_app   = bit_cnt_q + ONE_CNT;
        end
        // Short words are left-aligned with zero LSBs
        closed_word = (cnt_app < FULL_CNT) ? (shift_app << (FULL_CNT - cnt_app)) : shift_app;
        lr_edge     = (lr != lr_prev_q);

        if (bclk_rise) begin
            lr_prev_d = lr;
        end

        if (!bus.enable) begin
            state_d   = WAIT_SYNC;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (bclk_rise) begin
            case (state_q)
                WAIT_SYNC: begin
                    if (lr_edge && (lr == LR_LEFT)) begin
                        state_d   = LEFT;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                LEFT, RIGHT: begin
                    bit_cnt_d = cnt_app;
                    shift_d   = shift_app;
                    if (lr_edge) begin
                        bit_cnt_d    = '0;
                        shift_d      = '0;
                        short_word_d = (cnt_app < FULL_CNT);
                        if (state_q == LEFT) begin
                            left_hold_d = closed_word;
                            state_d     = RIGHT;
                        end else begin
                            line_l_d = left_hold_q;
                            line_r_d = closed_word;
                            pub_d    = 1'b1;
                            state_d  = LEFT;
                        end
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_SYNC;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            line_l_q     <= '0;
            line_r_q     <= '0;
            lr_prev_q    <= 1'b0;
            pub_q        <= 1'b0;
            new_sample_q <= 1'b0;
            short_word_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            line_l_q     <= line_l_d;
            line_r_q     <= line_r_d;
            lr_prev_q    <= lr_prev_d;
            pub_q        <= pub_d;
            new_sample_q <= new_sample_d;
            short_word_q <= short_word_d;
        end
    end

    assign bus.line_in_l  = line_l_q;
    assign bus.line_in_r  = line_r_q;
    assign bus.new_sample = new_sample_q;
    assign bus.short_word = short_word_q;
    assign bus.synced     = (state_q != WAIT_SYNC);
endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb_i2s_rx_deserializer
// Drives a continuous I2S bit stream frame by frame. A frame-level model
// predicts which L/R pairs must be published and queues them; a monitor on
// the system clock pops and compares on every new_sample pulse.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;
    localparam int SW   = 24;
    localparam int SYNC = 2;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } pair_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2s_rx_deserializer_if #(.SAMPLE_WIDTH(SW)) bus ();

    i2s_rx_deserializer #(
        .SAMPLE_WIDTH (SW),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    vectors    = 0;
    int    miscompares = 0;
    int    ratio      = 8;
    int    cyc        = 0;
    int    rise_cyc   = 0;
    int    sw_cnt     = 0;
    int    ns_cnt     = 0;
    int    push_cnt   = 0;
    bit    cur_lr     = 1'b0;
    bit    carry      = 1'b0;
    bit    pending_valid = 1'b0;
    pair_t pending;
    pair_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected captured word: first SW bits of a long slot, or an n-bit word
    // left-aligned for a short slot.
    function automatic logic [SW-1:0] expect_word(input logic [SW-1:0] v, input int n);
        logic [SW-1:0] mask;
        if (n >= SW) return v;
        mask = (24'h000001 << n) - 24'h000001;
        return (v & mask) << (SW - n);
    endfunction

    // Bit i (0 = first after the LR edge) of a slot of n bits carrying v
    function automatic bit slot_bit(input logic [SW-1:0] v, input int n, input int i);
        if (n >= SW) return (i < SW) ? v[SW-1-i] : 1'b0;
        return v[n-1-i];
    endfunction

    task automatic send_slot(input bit lr, input logic [SW-1:0] v, input int n, input bit mark);
        int half;
        half = ratio * 5;
        for (int i = 0; i < n; i++) begin
            bus.i2s_bclk  = 1'b0;
            bus.i2s_lrclk = lr;
            bus.i2s_sdata = (i == 0) ? carry : slot_bit(v, n, i - 1);
            #(half);
            bus.i2s_bclk = 1'b1;
            if (mark && i == 0) rise_cyc = cyc;
            #(half);
        end
        carry  = slot_bit(v, n, n - 1);
        cur_lr = lr;
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int n);
        if (cur_lr == 1'b1) begin
            // A 1->0 LRCLK edge closes the previous frame; it is published
            // only if the receiver saw that frame from its start.
            if (pending_valid) begin
                exp_q.push_back(pending);
                push_cnt++;
            end
            pending.l     = expect_word(l, n);
            pending.r     = expect_word(r, n);
            pending_valid = 1'b1;
        end else begin
            pending_valid = 1'b0;
        end
        send_slot(1'b0, l, n, 1'b1);
        send_slot(1'b1, r, n, 1'b0);
    endtask

    function automatic logic [SW-1:0] rnd24();
        return SW'($urandom());
    endfunction

    task automatic reset_mid_right(input int n);
        int slot_ns;
        slot_ns = n * ratio * 10;
        fork
            send_frame(rnd24(), rnd24(), n);
            begin
                #(slot_ns + $urandom_range(50, slot_ns - 200));
                reset = 1'b1;
                pending_valid = 1'b0;
                #1;
                check("rst_line_in_l", 32'(bus.line_in_l), 32'h0);
                check("rst_line_in_r", 32'(bus.line_in_r), 32'h0);
                check("rst_synced", 32'(bus.synced), 32'h0);
                check("rst_new_sample", 32'(bus.new_sample), 32'h0);
                #22;
                reset = 1'b0;
            end
        join
        send_frame(rnd24(), rnd24(), n);
        send_frame(rnd24(), rnd24(), n);
        send_frame(rnd24(), rnd24(), n);
    endtask

    // Monitor / scoreboard
    logic [SW-1:0] prev_l = '0, prev_r = '0;
    bit            chg_pending = 1'b0;
    always @(negedge clk) begin
        pair_t p;
        if (reset) begin
            chg_pending = 1'b0;
        end else begin
            if (chg_pending) begin
                check("pulse_after_update", 32'(bus.new_sample), 32'h1);
                chg_pending = 1'b0;
            end
            if (bus.new_sample) begin
                ns_cnt++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_new_sample: got l=%h r=%h, expected no pulse (t=%0t)",
                             bus.line_in_l, bus.line_in_r, $time);
                end else begin
                    p = exp_q.pop_front();
                    check("line_in_l", 32'(bus.line_in_l), 32'(p.l));
                    check("line_in_r", 32'(bus.line_in_r), 32'(p.r));
                    check("latency", 32'(cyc - rise_cyc), 32'(SYNC + 2));
                end
            end
            if (bus.short_word) sw_cnt++;
            if (bus.line_in_l !== prev_l || bus.line_in_r !== prev_r) chg_pending = 1'b1;
        end
        prev_l = bus.line_in_l;
        prev_r = bus.line_in_r;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sw0, n;
        logic [SW-1:0] hold_l, hold_r;
        reset         = 1'b1;
        bus.enable    = 1'b1;
        bus.i2s_bclk  = 1'b0;
        bus.i2s_lrclk = 1'b0;
        bus.i2s_sdata = 1'b0;
        #23;
        check("reset_line_in_l", 32'(bus.line_in_l), 32'h0);
        check("reset_line_in_r", 32'(bus.line_in_r), 32'h0);
        check("reset_new_sample", 32'(bus.new_sample), 32'h0);
        check("reset_short_word", 32'(bus.short_word), 32'h0);
        check("reset_synced", 32'(bus.synced), 32'h0);
        #10;
        reset = 1'b0;
        #50;
        check("idle_synced", 32'(bus.synced), 32'h0);

        // 64-BCLK frames; first pair unpublished, second published
        for (int i = 0; i < 3; i++) send_frame(24'hA5F00F, 24'h123456, 32);
        check("synced_after_lock", 32'(bus.synced), 32'h1);

        // Back-to-back extreme values, no short words
        sw0 = sw_cnt;
        send_frame(24'h800000, 24'h7FFFFF, 32);
        send_frame(24'h000001, 24'hFFFFFF, 32);
        send_frame(rnd24(), rnd24(), 32);
        #200;
        check("no_short_word_32", 32'(sw_cnt - sw0), 32'h0);

        // 24-bit slots: LSB rides on the LR-edge bit
        sw0 = sw_cnt;
        send_frame(24'hC00003, rnd24(), 24);
        send_frame(rnd24(), rnd24(), 32);
        #200;
        check("no_short_word_24", 32'(sw_cnt - sw0), 32'h0);

        // 20-bit slots: left-aligned, one short_word per slot
        sw0 = sw_cnt;
        send_frame(24'h0ABCDE, rnd24(), 20);
        send_frame(24'h0ABCDE, rnd24(), 20);
        send_frame(rnd24(), rnd24(), 32);
        #200;
        check("short_word_count_20", 32'(sw_cnt - sw0), 32'h4);

        // Randomized frames with mixed slot lengths
        for (int i = 0; i < 6; i++) begin
            n = 20 + 4 * $urandom_range(0, 3);
            send_frame(rnd24(), rnd24(), n);
        end
        send_frame(rnd24(), rnd24(), 32);

        // enable dropped mid-left-slot for 10 clk
        fork
            send_frame(rnd24(), rnd24(), 32);
            begin
                #1000;
                hold_l = bus.line_in_l;
                hold_r = bus.line_in_r;
                bus.enable = 1'b0;
                pending_valid = 1'b0;
                #50;
                check("enable_low_synced", 32'(bus.synced), 32'h0);
                #50;
                bus.enable = 1'b1;
                check("enable_low_hold_l", 32'(bus.line_in_l), 32'(hold_l));
                check("enable_low_hold_r", 32'(bus.line_in_r), 32'(hold_r));
            end
        join
        send_frame(rnd24(), rnd24(), 32);
        send_frame(rnd24(), rnd24(), 32);
        send_frame(rnd24(), rnd24(), 32);

        // Async reset mid-right-slot at random phase, two BCLK ratios
        ratio = 8;
        reset_mid_right(32);
        ratio = 33;
        reset_mid_right(32);

        #2000;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("pulse_count", 32'(ns_cnt), 32'(push_cnt));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
